// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - shares the work RAM port between the Z80 bus and the hiscore engine
// Optional pause_ack timeout: define HS_ARB_TIMEOUT_EN.
module hs_ram_arbiter #(
  parameter int AW      = 16,
  parameter int RAM_LAT = 1,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  output logic [7:0]    cpu_din,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  input  logic          hs_access,
  output logic [7:0]    hs_data_out,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          hs_grant,
  output logic          timeout_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_GRANT   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Settle counter is loaded one above GUARD so the grant lands GUARD+1 edges after the ack edge.
  localparam logic [4:0] SETTLE_LOAD = 5'(GUARD + 1);

  generate
    if (RAM_LAT < 1 || RAM_LAT > 2 || GUARD < 0 || GUARD > 15 ||
        TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_param
      $error("hs_ram_arbiter: parameter out of legal range");
    end
  endgenerate

  logic [2:0] state_q, state_d;
  logic [4:0] settle_q, settle_d;
  logic       pause_req_q;
  logic       hs_grant_q;
  logic [7:0] hs_data_q;
  logic       to_fire;

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] to_cnt_q, to_cnt_d;
  logic        timeout_err_q;

  // Counts consecutive REQ cycles without pause_ack; cleared whenever REQ is left.
  always_comb begin
    to_cnt_d = '0;
    to_fire  = 1'b0;
    if (state_q == ST_REQ && hs_access && !pause_ack) begin
      if (to_cnt_q == TO_LAST) begin
        to_fire = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_q | to_fire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_access) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!hs_access) begin
          state_d = ST_IDLE;
        end else if (pause_ack) begin
          settle_d = SETTLE_LOAD;
          state_d  = (GUARD == 0) ? ST_GRANT : ST_SETTLE;
        end else if (to_fire) begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!hs_access) begin
          state_d = ST_RELEASE;
        end else if (settle_q == 5'd1) begin
          state_d = ST_GRANT;
        end else begin
          settle_d = settle_q - 5'd1;
        end
      end
      ST_GRANT: begin
        if (!hs_access) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      pause_req_q <= 1'b0;
      hs_grant_q  <= 1'b0;
      hs_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pause_req_q <= (state_d != ST_IDLE);
      hs_grant_q  <= (state_d == ST_GRANT);
      if (state_q == ST_GRANT) hs_data_q <= ram_dout;
    end
  end

  assign ram_addr    = hs_grant_q ? hs_address : cpu_addr;
  assign ram_din     = hs_grant_q ? hs_data_in : cpu_dout;
  assign ram_we      = hs_grant_q ? hs_write   : cpu_we;
  assign cpu_din     = ram_dout;
  assign hs_data_out = hs_data_q;
  assign pause_req   = pause_req_q;
  assign hs_grant    = hs_grant_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - randomized bench for hs_ram_arbiter against a behavioural model
module tb_hs_ram_arbiter;
  localparam int AW      = 16;
  localparam int RAM_LAT = 1;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_dout = '0;
  logic          cpu_we = 1'b0;
  logic [7:0]    cpu_din;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic [AW-1:0] hs_address = '0;
  logic [7:0]    hs_data_in = '0;
  logic          hs_write = 1'b0;
  logic          hs_access = 1'b0;
  logic [7:0]    hs_data_out;
  logic          pause_req;
  logic          pause_ack = 1'b0;
  logic          hs_grant;
  logic          timeout_err;

  hs_ram_arbiter #(.AW(AW), .RAM_LAT(RAM_LAT), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_access(hs_access), .hs_data_out(hs_data_out),
    .pause_req(pause_req), .pause_ack(pause_ack), .hs_grant(hs_grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Work RAM with RAM_LAT-cycle registered read, read-before-write.
  logic [7:0] mem [0:65535];
  logic [7:0] rd1 = 8'h00, rd2 = 8'h00;
  assign ram_dout = (RAM_LAT == 1) ? rd1 : rd2;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[16'h0040] = 8'hA5;
    forever begin
      @(posedge clk);
      rd1 <= mem[ram_addr];
      rd2 <= rd1;
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  // Model: phase 0 idle, 1 waiting for ack, 2 settling, 3 granted, 4 handing back.
  int         ph = 0;
  int         ecnt = 0;
  int         grant_edge = 0;
  int         wait_n = 0;
  bit         m_terr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_rd1 = 8'h00, m_rd2 = 8'h00, mrd;
  logic [7:0] shadow [0:65535];
  logic [AW-1:0] e_a;
  logic [7:0] e_d;
  logic       e_w;

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = 8'(i) ^ 8'h3C;
    shadow[16'h0040] = 8'hA5;
    forever begin
      @(posedge clk);
      ecnt++;
      e_a = (ph == 3) ? hs_address : cpu_addr;
      e_d = (ph == 3) ? hs_data_in : cpu_dout;
      e_w = (ph == 3) ? hs_write   : cpu_we;
      mrd = (RAM_LAT == 1) ? m_rd1 : m_rd2;
      m_rd2 = m_rd1;
      m_rd1 = shadow[e_a];
      if (e_w) shadow[e_a] = e_d;
      if (!reset_n) begin
        ph = 0;
        m_data = 8'h00;
        m_terr = 1'b0;
      end else begin
        if (ph == 3) m_data = mrd;
        case (ph)
          0: if (hs_access) begin ph = 1; wait_n = 0; end
          1: begin
            if (!hs_access) ph = 0;
            else if (pause_ack) begin
              if (GUARD == 0) ph = 3;
              else begin ph = 2; grant_edge = ecnt + GUARD + 1; end
            end
`ifdef HS_ARB_TIMEOUT_EN
            else begin
              wait_n++;
              if (wait_n == TIMEOUT) begin ph = 0; m_terr = 1'b1; end
            end
`endif
          end
          2: if (!hs_access) ph = 4; else if (ecnt == grant_edge) ph = 3;
          3: if (!hs_access) ph = 4;
          default: ph = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pause_req",   32'(pause_req),   32'(ph != 0));
      chk("hs_grant",    32'(hs_grant),    32'(ph == 3));
      chk("hs_data_out", 32'(hs_data_out), 32'(m_data));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("ram_addr",    32'(ram_addr),    32'((ph == 3) ? hs_address : cpu_addr));
      chk("ram_din",     32'(ram_din),     32'((ph == 3) ? hs_data_in : cpu_dout));
      chk("ram_we",      32'(ram_we),      32'((ph == 3) ? hs_write : cpu_we));
      chk("cpu_din",     32'(cpu_din),     32'(ram_dout));
    end
  end

  initial begin
    reset_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;

    // CPU owns the port straight out of reset
    cpu_addr = 16'h1234; cpu_dout = 8'h11; cpu_we = 1'b1;
    #1;
    chk("rst_ram_addr", 32'(ram_addr), 32'h1234);
    chk("rst_ram_we", 32'(ram_we), 32'd1);
    chk("rst_pause_req", 32'(pause_req), 32'd0);
    chk("rst_hs_grant", 32'(hs_grant), 32'd0);
    chk("rst_hs_data", 32'(hs_data_out), 32'h00);
    tick();
    cpu_we = 1'b0;

    // Read: access at edge 0, ack sampled at edge 3, grant after edge 6
    hs_address = 16'h0040;
    hs_access = 1'b1;
    repeat (3) tick();
    pause_ack = 1'b1;
    repeat (3) tick();
    chk("grant_not_yet", 32'(hs_grant), 32'd0);
    tick();
    chk("grant_edge6", 32'(hs_grant), 32'd1);
    repeat (RAM_LAT + 1) tick();
    chk("read_a5", 32'(hs_data_out), 32'hA5);

    // Write during grant while the CPU also tries to write
    hs_address = 16'h0041; hs_data_in = 8'h5A; hs_write = 1'b1;
    cpu_addr = 16'h0080; cpu_dout = 8'h77; cpu_we = 1'b1;
    #1;
    chk("wr_ram_addr", 32'(ram_addr), 32'h0041);
    tick();
    hs_write = 1'b0; cpu_we = 1'b0;
    #1;
    chk("wr_mem41", 32'(mem[16'h0041]), 32'h5A);
    chk("wr_cpu_blocked", 32'(mem[16'h0080]), 32'hBC);

    // Hand back: grant drops first, pause one edge later; re-access ignored in RELEASE
    hs_access = 1'b0;
    tick();
    chk("rel_grant", 32'(hs_grant), 32'd0);
    chk("rel_pause", 32'(pause_req), 32'd1);
    hs_access = 1'b1;
    tick();
    chk("rel_idle", 32'(pause_req), 32'd0);
    tick();
    chk("rel_reenter", 32'(pause_req), 32'd1);
    repeat (4) tick();
    chk("regrant", 32'(hs_grant), 32'd1);

    // Reset during grant
    reset_n = 1'b0;
    tick();
    chk("rstg_grant", 32'(hs_grant), 32'd0);
    chk("rstg_pause", 32'(pause_req), 32'd0);
    cpu_addr = 16'h2222;
    #1;
    chk("rstg_addr", 32'(ram_addr), 32'h2222);
    reset_n = 1'b1; hs_access = 1'b0; pause_ack = 1'b0;
    repeat (2) tick();

    // Cancel in REQ before ack
    hs_access = 1'b1;
    tick();
    chk("cancel_req", 32'(pause_req), 32'd1);
    hs_access = 1'b0;
    tick();
    chk("cancel_idle", 32'(pause_req), 32'd0);
    repeat (3) begin
      tick();
      chk("cancel_nogrant", 32'(hs_grant), 32'd0);
    end

    hs_access = 1'b1;
    tick();
`ifdef HS_ARB_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    chk("to_before", 32'(timeout_err), 32'd0);
    tick();
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_pause", 32'(pause_req), 32'd0);
    tick();
    chk("to_reenter", 32'(pause_req), 32'd1);
    chk("to_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (40) tick();
    chk("wait_pause", 32'(pause_req), 32'd1);
    chk("wait_noerr", 32'(timeout_err), 32'd0);
`endif
    hs_access = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) hs_access = ~hs_access;
      if ($urandom_range(0, 4) == 0) pause_ack = ~pause_ack;
      reset_n    = ($urandom_range(0, 299) != 0);
      cpu_addr   = {8'h00, 8'($urandom_range(0, 255))};
      cpu_dout   = 8'($urandom_range(0, 255));
      cpu_we     = ($urandom_range(0, 3) == 0);
      hs_address = {8'h00, 8'($urandom_range(0, 255))};
      hs_data_in = 8'($urandom_range(0, 255));
      hs_write   = ($urandom_range(0, 3) == 0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
